// File: rtl/nx_msg_arbiter_pkg.sv
// Shared nexus definitions: arbiter ownership states and outbound source ids.
package nx_msg_arbiter_pkg;

  typedef enum logic {
    OWN_A = 1'b0,
    OWN_B = 1'b1
  } own_e;

  localparam logic SRC_CTRL = 1'b0;
  localparam logic SRC_MESH = 1'b1;

  localparam int BURST_W = 4;

endpackage

// File: rtl/nx_msg_slot.sv
// Single registered output slot: 1-cycle latency, full throughput, holds while stalled.
module nx_msg_slot #(
  parameter int W = 28
) (
  input  logic         i_clk,
  input  logic         i_rst,
  input  logic [W-1:0] up_data,
  input  logic         up_valid,
  output logic         up_ready,
  output logic [W-1:0] dn_data,
  output logic         dn_valid,
  input  logic         dn_ready
);

  // Writable when empty or when the held word leaves this cycle.
  assign up_ready = !dn_valid || dn_ready;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      dn_valid <= 1'b0;
      dn_data  <= '0;
    end else if (up_ready) begin
      dn_valid <= up_valid;
      if (up_valid) dn_data <= up_data;
    end
  end

endmodule

// File: rtl/nx_msg_arbiter.sv
// Two-source Nexus message arbiter with bounded bursts into one registered slot.
// Build option: define NX_MSG_ARB_COUNT_EN to enable the per-source grant counters.
//
// state | meaning
// OWN_A | control stream (A) owns the grant, burst counts A transfers
// OWN_B | mesh stream (B) owns the grant, burst counts B transfers
module nx_msg_arbiter
  import nx_msg_arbiter_pkg::*;
#(
  parameter int DATA_W    = 27,
  parameter int BURST_MAX = 4
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic [DATA_W-1:0] i_a_data,
  input  logic              i_a_valid,
  output logic              o_a_ready,
  input  logic [DATA_W-1:0] i_b_data,
  input  logic              i_b_valid,
  output logic              o_b_ready,
  output logic [DATA_W-1:0] o_ob_data,
  output logic              o_ob_src,
  output logic              o_ob_valid,
  input  logic              i_ob_ready,
  output logic [15:0]       o_cnt_a,
  output logic [15:0]       o_cnt_b
);

  own_e               state, state_nxt;
  logic [BURST_W-1:0] burst, burst_nxt;
  logic               writable;
  logic               at_max;
  logic               own_valid, oth_valid;
  logic               own_ready, oth_ready;
  logic               xfer_a, xfer_b, xfer_own, xfer_oth;
  logic [DATA_W:0]    slot_in, slot_out;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state <= OWN_A;
      burst <= '0;
    end else begin
      state <= state_nxt;
      burst <= burst_nxt;
    end
  end

  // Each ready looks only at the opposite source's valid, never its own.
  always_comb begin
    at_max    = (burst == BURST_W'(BURST_MAX));
    own_valid = (state == OWN_A) ? i_a_valid : i_b_valid;
    oth_valid = (state == OWN_A) ? i_b_valid : i_a_valid;
    own_ready = writable && !i_rst && !(at_max && oth_valid);
    oth_ready = writable && !i_rst && (at_max || !own_valid);
    o_a_ready = (state == OWN_A) ? own_ready : oth_ready;
    o_b_ready = (state == OWN_A) ? oth_ready : own_ready;
    xfer_a    = i_a_valid && o_a_ready;
    xfer_b    = i_b_valid && o_b_ready;
    xfer_own  = (state == OWN_A) ? xfer_a : xfer_b;
    xfer_oth  = (state == OWN_A) ? xfer_b : xfer_a;
    state_nxt = state;
    burst_nxt = burst;
    if (xfer_oth) begin
      state_nxt = (state == OWN_A) ? OWN_B : OWN_A;
      burst_nxt = BURST_W'(1);
    end else if (xfer_own && !at_max) begin
      burst_nxt = burst + BURST_W'(1);
    end
  end

  assign slot_in = xfer_b ? {SRC_MESH, i_b_data} : {SRC_CTRL, i_a_data};

  nx_msg_slot #(.W(DATA_W + 1)) u_slot (
    .i_clk    (i_clk),
    .i_rst    (i_rst),
    .up_data  (slot_in),
    .up_valid (xfer_a || xfer_b),
    .up_ready (writable),
    .dn_data  (slot_out),
    .dn_valid (o_ob_valid),
    .dn_ready (i_ob_ready)
  );

  assign o_ob_src  = slot_out[DATA_W];
  assign o_ob_data = slot_out[DATA_W-1:0];

`ifdef NX_MSG_ARB_COUNT_EN
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      o_cnt_a <= '0;
      o_cnt_b <= '0;
    end else begin
      if (xfer_a) o_cnt_a <= o_cnt_a + 16'd1;
      if (xfer_b) o_cnt_b <= o_cnt_b + 16'd1;
    end
  end
`else
  assign o_cnt_a = '0;
  assign o_cnt_b = '0;
`endif

endmodule
